// File: rtl/pkt_frame_pkg.sv
// ---------------------------------------------------------------------------
// pkt_frame_pkg
// Shared framing definitions for the packet builder / deframer pair:
//   - data_sel opcode constants (OP0/OP1/OP2)
//   - header size and maximum framed packet size in bytes
//   - deframer FSM state encoding
//   - payload_len(): payload byte count implied by a header byte
// ---------------------------------------------------------------------------
package pkt_frame_pkg;

  localparam logic [3:0] OP0 = 4'd0;
  localparam logic [3:0] OP1 = 4'd1;
  localparam logic [3:0] OP2 = 4'd2;

  localparam logic [4:0] HDR_BYTES     = 5'd2;
  localparam logic [4:0] MAX_PKT_BYTES = 5'd19;

  typedef enum logic [1:0] {
    BEAT_WAIT = 2'd0,
    EMIT      = 2'd1,
    DRAIN     = 2'd2,
    DONE      = 2'd3
  } deframer_state_t;

  // Payload length L for a header {data_sel, byte_cnt}; result is 1..16.
  function automatic logic [4:0] payload_len(input logic [3:0] data_sel,
                                             input logic [3:0] byte_cnt);
    logic [4:0] len_v;
    if (data_sel == OP0) begin
      len_v = {3'b000, byte_cnt[3:2]} + 5'd1;
    end else if (data_sel == OP1) begin
      len_v = {2'b00, byte_cnt[3:2], 1'b0} +
              ((byte_cnt[1:0] == 2'b00) ? 5'd1 : 5'd2);
    end else begin
      // OP2 and every larger opcode use the raw byte count
      len_v = {1'b0, byte_cnt} + 5'd1;
    end
    return len_v;
  endfunction

endpackage

// File: rtl/crc8_byte_update.sv
// ---------------------------------------------------------------------------
// crc8_byte_update
// Combinational one-byte CRC8 step, MSB-first, no reflection, no final XOR.
// Shared by the packet builder and the deframer.
// Ports:
//   crc_in  [7:0]  current CRC register value
//   data    [7:0]  byte to fold in
//   poly    [7:0]  generator polynomial (implicit x^8 term)
//   crc_out [7:0]  CRC register value after folding in data
// ---------------------------------------------------------------------------
module crc8_byte_update (
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  input  logic [7:0] poly,
  output logic [7:0] crc_out
);

  function automatic logic [7:0] crc8_step(input logic [7:0] crc_v,
                                           input logic [7:0] data_v,
                                           input logic [7:0] poly_v);
    logic [7:0] reg_v;
    reg_v = crc_v ^ data_v;
    for (int i = 0; i < 8; i++) begin
      if (reg_v[7]) begin
        reg_v = {reg_v[6:0], 1'b0} ^ poly_v;
      end else begin
        reg_v = {reg_v[6:0], 1'b0};
      end
    end
    return reg_v;
  endfunction

  // Fold one byte into the CRC
  always_comb begin
    crc_out = crc8_step(crc_in, data, poly);
  end

endmodule

// File: rtl/packet_deframer.sv
// ---------------------------------------------------------------------------
// packet_deframer
// Accepts 32-bit little-endian beats of a framed packet
//   {byte0 = {data_sel, byte_cnt}, byte1 reserved, L payload bytes, CRC8},
// strips the header, checks the trailing CRC8 and emits the payload one byte
// per cycle. Header fields and CRC/length status are reported per packet.
//
// Configuration macro: DEFRAMER_CRC_PASS_EN
//   defined   - the CRC byte is also emitted as the final m_byte (with m_last)
//   undefined - the CRC byte is consumed internally
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   beat input (one beat buffered at most)
//   m_byte/m_valid/m_last/m_ready   payload byte output
//   hdr_byte_cnt, hdr_data_sel      header fields of the current packet
//   pkt_done          one-cycle end-of-packet pulse
//   crc_err, len_err  status, valid with pkt_done, held until next header
// ---------------------------------------------------------------------------
module packet_deframer
  import pkt_frame_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = 8'h07,
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_byte,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [3:0]  hdr_byte_cnt,
  output logic [3:0]  hdr_data_sel,
  output logic        pkt_done,
  output logic        crc_err,
  output logic        len_err
);

  deframer_state_t state_r;
  deframer_state_t state_next_s;

  logic [4:0]  pos_r;
  logic [31:0] beat_r;
  logic        beat_last_r;
  logic [7:0]  crc_r;
  logic [4:0]  len_r;
  logic [3:0]  hdr_byte_cnt_r;
  logic [3:0]  hdr_data_sel_r;
  logic        crc_err_r;
  logic        len_err_r;

  logic [7:0]  cur_byte_s;
  logic [7:0]  crc_next_s;
  logic [4:0]  crc_pos_s;
  logic        is_hdr_s;
  logic        is_pay_s;
  logic        is_crc_s;
  logic        slot_end_s;
  logic        emit_s;
  logic        adv_s;
  logic        m_last_s;

  crc8_byte_update u_crc (
    .crc_in  (crc_r),
    .data    (cur_byte_s),
    .poly    (CRC_POLY),
    .crc_out (crc_next_s)
  );

  // Classify the buffered byte selected by the packet byte position
  always_comb begin
    cur_byte_s = beat_r[{pos_r[1:0], 3'b000} +: 8];
    // CRC byte sits at T-1 = L+2; len_r is only meaningful past the header
    crc_pos_s  = len_r + 5'd2;
    is_hdr_s   = (pos_r < HDR_BYTES);
    is_crc_s   = !is_hdr_s && (pos_r == crc_pos_s);
    is_pay_s   = !is_hdr_s && (pos_r < crc_pos_s);
    slot_end_s = (pos_r[1:0] == 2'b11);
`ifdef DEFRAMER_CRC_PASS_EN
    emit_s   = (state_r == EMIT) && (is_pay_s || is_crc_s);
    m_last_s = is_crc_s || (is_pay_s && beat_last_r && slot_end_s);
`else
    emit_s   = (state_r == EMIT) && is_pay_s;
    m_last_s = is_pay_s &&
               ((pos_r == (crc_pos_s - 5'd1)) || (beat_last_r && slot_end_s));
`endif
    // Non-emitted bytes advance unconditionally; emitted ones wait for m_ready
    adv_s = (state_r == EMIT) && (!emit_s || m_ready);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= BEAT_WAIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BEAT_WAIT: begin
        if (s_valid) begin
          state_next_s = EMIT;
        end else begin
          state_next_s = BEAT_WAIT;
        end
      end
      EMIT: begin
        if (!adv_s) begin
          state_next_s = EMIT;
        end else if (is_crc_s) begin
          state_next_s = beat_last_r ? DONE : DRAIN;
        end else if (slot_end_s) begin
          // Beat exhausted before the CRC byte: fetch more, or terminate early
          state_next_s = beat_last_r ? DONE : BEAT_WAIT;
        end else begin
          state_next_s = EMIT;
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        state_next_s = BEAT_WAIT;
      end
      default: begin
        state_next_s = BEAT_WAIT;
      end
    endcase
  end

  // FSM outputs, all forced low while reset is asserted
  always_comb begin
    if (reset) begin
      s_ready      = 1'b0;
      m_valid      = 1'b0;
      m_byte       = 8'h00;
      m_last       = 1'b0;
      pkt_done     = 1'b0;
      hdr_byte_cnt = 4'h0;
      hdr_data_sel = 4'h0;
      crc_err      = 1'b0;
      len_err      = 1'b0;
    end else begin
      s_ready      = (state_r == BEAT_WAIT) || (state_r == DRAIN);
      m_valid      = emit_s;
      m_byte       = emit_s ? cur_byte_s : 8'h00;
      m_last       = emit_s && m_last_s;
      pkt_done     = (state_r == DONE);
      hdr_byte_cnt = hdr_byte_cnt_r;
      hdr_data_sel = hdr_data_sel_r;
      crc_err      = crc_err_r;
      len_err      = len_err_r;
    end
  end

  // Beat buffer, byte position, CRC register and per-packet status
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r          <= 5'd0;
      beat_r         <= 32'h0000_0000;
      beat_last_r    <= 1'b0;
      crc_r          <= CRC_INIT;
      len_r          <= 5'd0;
      hdr_byte_cnt_r <= 4'h0;
      hdr_data_sel_r <= 4'h0;
      crc_err_r      <= 1'b0;
      len_err_r      <= 1'b0;
    end else begin
      case (state_r)
        BEAT_WAIT: begin
          if (s_valid) begin
            beat_r      <= s_data;
            beat_last_r <= s_last;
          end
        end
        EMIT: begin
          if (adv_s) begin
            pos_r <= pos_r + 5'd1;
            if (!is_crc_s) begin
              crc_r <= crc_next_s;
            end
            if (pos_r == 5'd0) begin
              hdr_data_sel_r <= cur_byte_s[7:4];
              hdr_byte_cnt_r <= cur_byte_s[3:0];
              len_r          <= payload_len(cur_byte_s[7:4], cur_byte_s[3:0]);
              crc_err_r      <= 1'b0;
              len_err_r      <= 1'b0;
            end
            if (is_crc_s) begin
              crc_err_r <= (cur_byte_s != crc_r);
              // More beats follow the CRC byte: they will be drained
              len_err_r <= !beat_last_r;
            end else if (slot_end_s && beat_last_r) begin
              len_err_r <= 1'b1;
            end
          end
        end
        DRAIN: begin
          pos_r <= pos_r;
        end
        DONE: begin
          pos_r <= 5'd0;
          crc_r <= CRC_INIT;
        end
        default: begin
          pos_r <= pos_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_deframer.sv
// ---------------------------------------------------------------------------
// tb_packet_deframer
// Scoreboard bench: each scenario builds a packet, pushes the expected
// payload bytes and end-of-packet status, then drives the beats. A negedge
// monitor pops and compares emitted bytes and pkt_done status.
// ---------------------------------------------------------------------------
module tb_packet_deframer;

`ifdef DEFRAMER_CRC_PASS_EN
  localparam bit PASS_EN = 1'b1;
`else
  localparam bit PASS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = 32'h0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  m_byte;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [3:0]  hdr_byte_cnt;
  logic [3:0]  hdr_data_sel;
  logic        pkt_done;
  logic        crc_err;
  logic        len_err;

  always #5 clk = ~clk;

  packet_deframer dut (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .m_byte       (m_byte),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .hdr_byte_cnt (hdr_byte_cnt),
    .hdr_data_sel (hdr_data_sel),
    .pkt_done     (pkt_done),
    .crc_err      (crc_err),
    .len_err      (len_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];   // {last, byte}
  logic [1:0]  done_q[$];  // {crc_err, len_err}
  int          done_cnt = 0;
  logic        sb_en = 1'b0;
  int          rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  logic        prev_last = 1'b0;
  logic [7:0]  pkt [0:31];

  function automatic logic [7:0] crc8_model(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic int model_len(input logic [7:0] h);
    int ds, bc;
    ds = int'(h[7:4]);
    bc = int'(h[3:0]);
    if (ds == 0) return (bc / 4) + 1;
    if (ds == 1) return 2 * (bc / 4) + (((bc % 4) == 0) ? 1 : 2);
    return bc + 1;
  endfunction

  // Output monitor: drives m_ready, then checks what the next edge accepts
  always @(negedge clk) begin
    logic [8:0] e;
    logic [1:0] d;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (sb_en && !reset) begin
      if (prev_stall) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_byte !== prev_byte || m_last !== prev_last) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b b=%02h l=%0b, want v=1 b=%02h l=%0b",
                   m_valid, m_byte, m_last, prev_byte, prev_last);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL byte_out: got unexpected byte %02h last=%0b, want none", m_byte, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_byte} !== e) begin
            n_err++;
            $display("FAIL byte_out: got last=%0b byte=%02h, want last=%0b byte=%02h",
                     m_last, m_byte, e[8], e[7:0]);
          end
        end
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_byte  = m_byte;
      prev_last  = m_last;
      if (pkt_done === 1'b1) begin
        done_cnt++;
        n_cmp++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL pkt_status: got unexpected pkt_done, want none");
        end else begin
          d = done_q.pop_front();
          if ({crc_err, len_err} !== d) begin
            n_err++;
            $display("FAIL pkt_status: got crc_err=%0b len_err=%0b, want crc_err=%0b len_err=%0b",
                     crc_err, len_err, d[1], d[0]);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
      if (pkt_done === 1'b1) done_cnt++;
    end
  end

  // Random packet body with a correct trailing CRC
  task automatic fill_pkt(input logic [7:0] hdr);
    int t;
    logic [7:0] c;
    for (int i = 0; i < 32; i++) pkt[i] = 8'($urandom);
    pkt[0] = hdr;
    pkt[1] = 8'h00;
    t = model_len(hdr) + 3;
    c = 8'h00;
    for (int i = 0; i < t - 1; i++) c = crc8_model(c, pkt[i]);
    pkt[t - 1] = c;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) pkt[i] = 8'h00;
    for (int k = 0; k < 4; k++) pkt[k] = w[8*k +: 8];
  endtask

  // Push expectations for pkt[], drive beats 0..last_beat, wait for pkt_done
  task automatic play(input int last_beat, output int dones);
    int t, nb, start, cyc;
    logic [7:0] c;
    t  = model_len(pkt[0]) + 3;
    nb = 4 * (last_beat + 1);
    if (nb >= t) begin
      for (int p = 2; p <= t - 2; p++) exp_q.push_back({(p == t - 2) && !PASS_EN, pkt[p]});
      if (PASS_EN) exp_q.push_back({1'b1, pkt[t - 1]});
      c = 8'h00;
      for (int p = 0; p <= t - 2; p++) c = crc8_model(c, pkt[p]);
      done_q.push_back({pkt[t - 1] != c, last_beat != (t - 1) / 4});
    end else begin
      for (int p = 2; p <= nb - 1; p++) exp_q.push_back({p == nb - 1, pkt[p]});
      done_q.push_back(2'b01);
    end
    start = done_cnt;
    for (int b = 0; b <= last_beat; b++) begin
      @(negedge clk);
      s_data  = {pkt[4*b+3], pkt[4*b+2], pkt[4*b+1], pkt[4*b]};
      s_last  = (b == last_beat);
      s_valid = 1'b1;
      cyc = 0;
      while (s_ready !== 1'b1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    cyc = 0;
    while (done_cnt == start && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    dones = done_cnt - start;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_ready, m_valid, m_last, pkt_done, crc_err, len_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got rdy=%0b mv=%0b ml=%0b done=%0b ce=%0b le=%0b, want all 0",
               s_ready, m_valid, m_last, pkt_done, crc_err, len_err);
    end
    n_cmp++;
    if ({m_byte, hdr_data_sel, hdr_byte_cnt} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_data: got byte=%02h sel=%h cnt=%h, want 0", m_byte, hdr_data_sel, hdr_byte_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got s_ready=%0b, want 1", s_ready);
    end
    sb_en = 1'b1;
  endtask

  task automatic test_single_beat;
    int dn;
    rdy_mode = 0;
    load_word(32'h31A50020);
    play(0, dn);
    n_cmp++;
    if (dn !== 1) begin n_err++; $display("FAIL single_done: got %0d pkt_done, want 1", dn); end
    n_cmp++;
    if ({hdr_data_sel, hdr_byte_cnt, crc_err, len_err} !== 10'b0010_0000_0_0) begin
      n_err++;
      $display("FAIL single_status: got sel=%h cnt=%h ce=%0b le=%0b, want sel=2 cnt=0 ce=0 le=0",
               hdr_data_sel, hdr_byte_cnt, crc_err, len_err);
    end
  endtask

  task automatic test_crc_error;
    int dn;
    load_word(32'h32A50020);
    play(0, dn);
    n_cmp++;
    if (dn !== 1 || crc_err !== 1'b1) begin
      n_err++;
      $display("FAIL crc_error: got dones=%0d crc_err=%0b, want 1 and 1", dn, crc_err);
    end
  endtask

  task automatic test_backpressure;
    int dn;
    rdy_mode = 1;
    fill_pkt(8'h04);
    play(1, dn);
    n_cmp++;
    if (dn !== 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL backpressure: got dones=%0d left=%0d, want 1 and 0", dn, exp_q.size());
    end
    n_cmp++;
    if ({hdr_data_sel, hdr_byte_cnt} !== 8'h04) begin
      n_err++;
      $display("FAIL bp_header: got %h%h, want 04", hdr_data_sel, hdr_byte_cnt);
    end
    rdy_mode = 0;
  endtask

  task automatic test_early_last;
    int dn;
    fill_pkt(8'h2F);
    play(1, dn);
    n_cmp++;
    if (dn !== 1 || len_err !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL early_last: got dones=%0d len_err=%0b left=%0d, want 1 1 0", dn, len_err, exp_q.size());
    end
  endtask

  task automatic test_drain;
    int dn;
    fill_pkt(8'h20);
    play(2, dn);
    n_cmp++;
    if (dn !== 1 || len_err !== 1'b1 || crc_err !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got dones=%0d len_err=%0b crc_err=%0b, want 1 1 0", dn, len_err, crc_err);
    end
  endtask

  task automatic test_reset_mid_packet;
    int d0, dn;
    fill_pkt(8'h2F);
    sb_en = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    s_data  = {pkt[3], pkt[2], pkt[1], pkt[0]};
    s_valid = 1'b1;
    s_last  = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got s_ready=%0b m_valid=%0b, want 0 0", s_ready, m_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_ready: got s_ready=%0b, want 1", s_ready);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0) begin
      n_err++;
      $display("FAIL reset_mid_done: got %0d pkt_done pulses, want 0", done_cnt - d0);
    end
    exp_q.delete();
    done_q.delete();
    sb_en = 1'b1;
    fill_pkt(8'h2F);
    play(4, dn);
    n_cmp++;
    if (dn !== 1 || {crc_err, len_err} !== 2'b00 || {hdr_data_sel, hdr_byte_cnt} !== 8'h2F) begin
      n_err++;
      $display("FAIL after_reset: got dones=%0d ce=%0b le=%0b hdr=%h%h, want 1 0 0 2F",
               dn, crc_err, len_err, hdr_data_sel, hdr_byte_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int dn, t;
    logic [7:0] h;
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) begin
      h = {4'($urandom_range(0, 3)), 4'($urandom)};
      fill_pkt(h);
      t = model_len(h) + 3;
      play((t - 1) / 4, dn);
      n_cmp++;
      if (dn !== 1 || {crc_err, len_err} !== 2'b00 || {hdr_data_sel, hdr_byte_cnt} !== h) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got dones=%0d ce=%0b le=%0b hdr=%h%h, want 1 0 0 %02h",
                 i, dn, crc_err, len_err, hdr_data_sel, hdr_byte_cnt, h);
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_crc_error();
    test_backpressure();
    test_early_last();
    test_drain();
    test_reset_mid_packet();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d bytes and %0d status left, want 0 and 0",
               exp_q.size(), done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/packet_deframer.md
Name: packet_deframer

Overview:
- Receiving end of the packet builder's output stream: accepts 32-bit write-data beats of a framed packet and strips the 2-byte header.
- Checks the trailing CRC8 and emits the dense payload as a byte stream.
- Sits downstream of the packet builder's write channel and acts as the write-data responder.
- Reports header fields and CRC/length status per packet.

Parameters:
- CRC_POLY, 8'h07, CRC8 polynomial; MSB-first, no reflection, no final XOR.
- CRC_INIT, 8'h00, CRC register value at the start of each packet.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_data  in  32  write beat; byte k of the packet sits at s_data[8*(k%4)+:8] (little-endian)
- s_valid  in  1  beat valid
- s_last  in  1  final beat of packet
- s_ready  out  1  beat accepted when s_valid && s_ready
- m_byte  out  8  payload byte
- m_valid  out  1  payload byte valid
- m_last  out  1  final emitted byte of packet
- m_ready  in  1  downstream accept
- hdr_byte_cnt  out  4  header byte0[3:0]
- hdr_data_sel  out  4  header byte0[7:4]
- pkt_done  out  1  one-cycle pulse at end of packet
- crc_err  out  1  CRC mismatch; valid with pkt_done, held until next header accepted
- len_err  out  1  s_last early or missing; valid with pkt_done, held until next header accepted

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- While reset is high:
  - All outputs are 0, and s_ready is forced to 0.
  - The FSM goes to BEAT_WAIT, the byte position is 0, and the CRC register is CRC_INIT.
- Reset mid-packet aborts the packet silently: no pkt_done is produced.
- Packet format:
  - byte0 = {data_sel, byte_cnt}; byte1 is reserved. Both header bytes are included in the CRC.
  - Then L payload bytes, then one CRC byte over byte0..last payload byte.
- Payload length L (in the package) is computed from byte_cnt (bc):
  - data_sel 0: bc[3:2]+1.
  - data_sel 1: 2*bc[3:2] + (bc[1:0]==0 ? 1 : 2).
  - data_sel 2 or greater: bc+1.
  - Total packet bytes T = L+3, at most 19, so at most 5 beats.
- FSM:
  - BEAT_WAIT:
    - s_ready=1.
    - On handshake, latch the beat and its last flag into the beat buffer, then go to EMIT.
  - EMIT:
    - Processes the buffered byte at pos%4, one byte per cycle, and maintains the 5-bit byte position pos.
    - pos 0: latch the hdr_* outputs and clear crc_err/len_err. No m_valid.
    - pos 1: consumed. No m_valid.
    - Payload bytes: m_valid=1. The byte advances only on m_ready; the CRC register is updated on the advance.
    - pos==T-1: compare the CRC byte against the CRC register; set crc_err on mismatch. No m_valid.
    - After the CRC byte, go to DONE (if the beat was last) or DRAIN (if not last; set len_err).
    - After the 4th byte of the beat: go to BEAT_WAIT. If the buffered beat was last before pos reached T-1, set len_err and go to DONE.
    - Bytes of the final beat after the CRC byte are ignored.
  - DRAIN:
    - s_ready=1; beats are discarded until an s_last handshake, then go to DONE.
  - DONE:
    - pkt_done=1 for one cycle.
    - pos←0, CRC←CRC_INIT, next state BEAT_WAIT.
- m_last:
  - Asserted on the payload byte with pos==T-2.
  - Also asserted on the final payload byte of a beat flagged last with pos<T-2 (early termination).
  - If an early-terminated packet emitted no payload byte, there is no m_last.
- Backpressure:
  - m_byte, m_valid and m_last hold stable while m_valid && !m_ready.
  - s_ready is 0 in EMIT and DONE, so at most one beat is buffered.
- Throughput: a 4-payload-byte beat needs 4 EMIT cycles plus 1 BEAT_WAIT cycle.

Optional Feature:
- Macro DEFRAMER_CRC_PASS_EN.
- Defined: the CRC byte is also emitted on m_byte as the final byte. m_last moves to the CRC byte; it is still compared.
- Undefined: the CRC byte is consumed internally and never emitted.

Decomposition:
- Package pkt_frame_pkg holds:
  - OP0/OP1/OP2 data_sel constants.
  - HDR_BYTES=2 and MAX_PKT_BYTES=19.
  - The deframer_state_t enum (BEAT_WAIT, EMIT, DRAIN, DONE).
  - A function payload_len(data_sel, byte_cnt).
- Sub-module crc8_byte_update (combinational: crc_in, data, poly → crc_out). It is shareable with the builder.

Test Plan:
- Single beat s_data=32'h31A50020, s_last=1, m_ready=1 → one byte 0xA5 with m_last; pkt_done; crc_err=0; len_err=0; hdr_data_sel=2; hdr_byte_cnt=0.
- Same with s_data=32'h32A50020 → 0xA5 emitted; crc_err=1 with pkt_done.
- Header 8'h04 (OP0, bc=4 → L=2), 2 beats with model-computed CRC, m_ready toggling 1/0 → 2 bytes in order; outputs stable during stalls; m_last on the 2nd; crc_err=0.
- Header 8'h2F (L=16), s_last on beat 2 → 6 payload bytes; m_last on the 6th; pkt_done with len_err=1.
- Header 8'h20 without s_last on beat 1, then 2 extra beats (last on the 2nd) → extras accepted and dropped; pkt_done after the final beat; len_err=1; crc_err=0.
- Reset pulse during EMIT of a 5-beat packet → no pkt_done; s_ready=1 the cycle after reset falls; the next valid packet decodes with no errors.
